// File: rtl/vga_timing_monitor.sv
// VGA sync timing monitor: tracks beam position, checks line/frame/hsync
// geometry, locks after consecutive good frames and counts timing errors.
module vga_timing_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       pix_en,
    input  logic       hs,
    input  logic       vs,
    input  logic       blank_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_count,
    output logic       frame_done
);

    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_LEN = 10'(H_SYNC);
    localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);
    localparam logic [9:0] SAT10  = 10'h3FF;

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    state_t     state, state_nx;
    logic       hs_q, vs_q;
    logic [9:0] low_cnt;
    logic [7:0] good_cnt, good_nx;
    logic       hs_fall, hs_rise, vs_fall;
    logic       any_err, err_nx, done_nx;

    assign hs_fall = hs_q & ~hs;
    assign hs_rise = ~hs_q & hs;
    assign vs_fall = vs_q & ~vs;
    assign locked  = (state == LOCKED);

    // All three checks use pre-update x/y/low_cnt and merge into one error
    assign any_err = (hs_rise && low_cnt != HS_LEN)
                   | (hs_fall && x != X_LAST)
                   | (vs_fall && y != Y_LAST);

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        err_nx   = 1'b0;
        done_nx  = 1'b0;
        unique case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_nx = ALIGN;
                    good_nx  = 8'd0;
                end
            end
            ALIGN: begin
                if (any_err) begin
                    err_nx   = 1'b1;
                    state_nx = SEARCH;
                    good_nx  = 8'd0;
                end else if (vs_fall) begin
                    good_nx = good_cnt + 8'd1;
                    if (good_nx == LOCK_N) begin
                        state_nx = LOCKED;
                        done_nx  = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (any_err) begin
                    err_nx   = 1'b1;
                    state_nx = SEARCH;
                    good_nx  = 8'd0;
                end else if (vs_fall) begin
                    done_nx = 1'b1;
                end
            end
            default: begin
                state_nx = SEARCH;
                good_nx  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SEARCH;
            good_cnt   <= 8'd0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            low_cnt    <= 10'd0;
            x          <= 10'd0;
            y          <= 10'd0;
            active     <= 1'b0;
            err        <= 1'b0;
            err_count  <= 8'd0;
            frame_done <= 1'b0;
        end else begin
            err        <= 1'b0;
            frame_done <= 1'b0;
            if (pix_en) begin
                state      <= state_nx;
                good_cnt   <= good_nx;
                hs_q       <= hs;
                vs_q       <= vs;
                active     <= blank_n;
                err        <= err_nx;
                frame_done <= done_nx;
                if (err_nx && err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
                if (hs_fall)
                    low_cnt <= 10'd1;
                else if (!hs && low_cnt != SAT10)
                    low_cnt <= low_cnt + 10'd1;
                if (hs_fall)
                    x <= 10'd0;
                else if (x != SAT10)
                    x <= x + 10'd1;
                if (vs_fall)
                    y <= 10'd0;
                else if (hs_fall && y != SAT10)
                    y <= y + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor: reduced-size raster, tick-level reference
// model, directed scenarios plus randomized pacing and fault injection.
module tb_vga_timing_monitor;

    localparam int HT = 40;
    localparam int HW = 6;
    localparam int VT = 12;
    localparam int LF = 2;

    logic       clk = 1'b0;
    logic       rst_n, pix_en, hs, vs, blank_n;
    logic [9:0] x, y;
    logic       active, locked, err, frame_done;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;
    int fd_seen = 0;
    int err_seen = 0;
    bit rnd = 1'b0;

    // reference model state: mode 0=search 1=align 2=locked
    int m_x, m_y, m_low, m_mode, m_good, m_ec;
    bit m_ph, m_pv, m_act, m_err, m_fd;

    always #5 clk = ~clk;

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_SYNC(HW), .V_TOTAL(VT), .LOCK_FRAMES(LF)
    ) dut (
        .CLOCK_50(clk), .reset_n(rst_n), .pix_en(pix_en),
        .hs(hs), .vs(vs), .blank_n(blank_n),
        .x(x), .y(y), .active(active), .locked(locked),
        .err(err), .err_count(err_count), .frame_done(frame_done)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_low = 0; m_mode = 0; m_good = 0; m_ec = 0;
        m_ph = 1; m_pv = 1; m_act = 0; m_err = 0; m_fd = 0;
    endtask

    task automatic model_tick(bit h, bit v, bit b);
        bit hf, hr, vf, e;
        hf = m_ph && !h;
        hr = !m_ph && h;
        vf = m_pv && !v;
        e = (hr && m_low != HW) || (hf && m_x != HT - 1) || (vf && m_y != VT - 1);
        m_err = 0;
        m_fd = 0;
        if (m_mode == 0) begin
            if (vf) begin m_mode = 1; m_good = 0; end
        end else if (e) begin
            m_err = 1; m_mode = 0; m_good = 0;
        end else if (vf) begin
            if (m_mode == 1) begin
                m_good++;
                if (m_good == LF) begin m_mode = 2; m_fd = 1; end
            end else begin
                m_fd = 1;
            end
        end
        if (m_err && m_ec < 255) m_ec++;
        m_low = hf ? 1 : (!h ? (m_low < 1023 ? m_low + 1 : 1023) : m_low);
        m_y = vf ? 0 : (hf ? (m_y < 1023 ? m_y + 1 : 1023) : m_y);
        m_x = hf ? 0 : (m_x < 1023 ? m_x + 1 : 1023);
        m_act = b;
        m_ph = h;
        m_pv = v;
    endtask

    function automatic int gap();
        return rnd ? int'($urandom_range(1, 3)) : 1;
    endfunction

    task automatic do_tick(bit h, bit v, bit b);
        int g;
        g = gap();
        pix_en = 1; hs = h; vs = v; blank_n = b;
        model_tick(h, v, b);
        @(posedge clk); #1;
        check("x", x, m_x);
        check("y", y, m_y);
        check("active", active, m_act);
        check("locked", locked, (m_mode == 2));
        check("err", err, m_err);
        check("frame_done", frame_done, m_fd);
        check("err_count", err_count, m_ec);
        if (frame_done) fd_seen++;
        if (err) err_seen++;
        pix_en = 0;
        for (int i = 0; i < g; i++) begin
            @(posedge clk); #1;
        end
        check("idle_err", err, 0);
        check("idle_fd", frame_done, 0);
        check("hold_x", x, m_x);
    endtask

    task automatic send_line(int len, int sync, bit vlow, bit vis);
        for (int t = 0; t < len; t++)
            do_tick(t >= sync, !vlow, vis && t >= sync + 2 && t < len - 2);
    endtask

    task automatic send_frame(int bad_line, int bad_len, int bad_sync);
        for (int l = 0; l < VT; l++)
            send_line(l == bad_line ? bad_len : HT,
                      l == bad_line ? bad_sync : HW,
                      l < 2, l >= 3 && l < VT - 1);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_x"}, x, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_ec"}, err_count, 0);
        check({tag, "_fd"}, frame_done, 0);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; pix_en = 0; hs = 1; vs = 1; blank_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1;

        // nominal: lock after third vs fall, then one frame_done per frame
        fd_seen = 0;
        send_frame(-1, HT, HW);
        send_frame(-1, HT, HW);
        check("align_unlocked", locked, 0);
        for (int f = 0; f < 3; f++) send_frame(-1, HT, HW);
        check("nom_locked", locked, 1);
        check("nom_fd", fd_seen, 3);
        check("nom_ec", err_count, 0);

        // one short line while locked, then relock
        err_seen = 0;
        send_frame(4, HT - 1, HW);
        check("short_err", err_seen, 1);
        check("short_ec", err_count, 1);
        check("short_unlocked", locked, 0);
        for (int f = 0; f < 3; f++) send_frame(-1, HT, HW);
        check("short_relock", locked, 1);

        // hsync one tick short while aligning
        pulse_reset();
        err_seen = 0;
        send_frame(3, HT, HW - 1);
        check("narrow_err", err_seen, 1);
        check("narrow_ec", err_count, 1);
        check("narrow_unlocked", locked, 0);

        // garbage without any vs fall stays silent
        pulse_reset();
        err_seen = 0;
        for (int i = 0; i < 400; i++)
            do_tick(1'($urandom), 1'b1, 1'($urandom));
        check("search_err", err_seen, 0);
        check("search_ec", err_count, 0);

        // 300 forced errors saturate the counter
        rnd = 1;
        err_seen = 0;
        for (int i = 0; i < 300; i++) begin
            do_tick(1, 1, 0);
            do_tick(0, 0, 0);
            do_tick(1, 1, 0);
        end
        check("sat_pulses", err_seen, 300);
        check("sat_ec", err_count, 255);
        rnd = 0;

        // lock, then asynchronous reset mid-frame
        for (int f = 0; f < 3; f++) send_frame(-1, HT, HW);
        check("pre_rst_locked", locked, 1);
        for (int l = 0; l < 5; l++) send_line(HT, HW, l < 2, l >= 3);
        for (int t = 0; t < 20; t++) do_tick(t >= HW, 1, 0);
        #2 rst_n = 0;
        #1 check_zero("async_rst");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        err_seen = 0;
        for (int t = 20; t < HT; t++) do_tick(1, 1, 0);
        for (int l = 6; l < VT; l++) send_line(HT, HW, 0, 1);
        for (int f = 0; f < 3; f++) send_frame(-1, HT, HW);
        check("rst_relock", locked, 1);
        check("rst_no_err", err_seen, 0);

        // randomized pacing and fault injection against the model
        rnd = 1;
        for (int f = 0; f < 10; f++) begin
            if ($urandom_range(0, 9) < 4) begin
                int bl, k;
                bl = $urandom_range(0, VT - 1);
                k = $urandom_range(0, 3);
                if (k < 2) send_frame(bl, k == 0 ? HT - 1 : HT + 1, HW);
                else send_frame(bl, HT, k == 2 ? HW - 1 : HW + 1);
            end else begin
                send_frame(-1, HT, HW);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
